// File: rtl/line_pingpong_pkg.sv
// Shared defaults and reset values for the ping-pong line store.
// Bank 0 and bank 1 swap roles at each accepted line_start.
package line_pingpong_pkg;

  localparam int WIDTH_DEF  = 320;
  localparam int DATA_W_DEF = 8;
  localparam int PTR_W_DEF  = $clog2(WIDTH_DEF);

  localparam int PTR_RST   = 0;
  localparam int PIXEL_RST = 0;

endpackage

// File: rtl/line_bank.sv
// One line of pixel storage: a single write port and a registered read port.
// The contents are never cleared by reset.
module line_bank #(
  parameter int WIDTH  = 320,
  parameter int DATA_W = 8,
  parameter int PTR_W  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_pingpong.sv
// Ping-pong line store. The host fills one bank while video reads the other.
// If no complete line is waiting at line_start, the last complete line is replayed.
module line_pingpong
  import line_pingpong_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready,
  input  logic              line_start,
  input  logic              next,
  output logic [DATA_W-1:0] pixel_o,
  output logic              valid,
  output logic              underrun
);

  localparam int PTR_W = $clog2(WIDTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(WIDTH - 1);

  logic             fill_sel, fill_full;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic             accept, swap;
  logic             fill_sel_next, fill_full_next, valid_next;
  logic [PTR_W-1:0] wr_ptr_next, rd_ptr_next;
  logic [DATA_W-1:0] rdata0, rdata1;

  assign ready  = !fill_full;
  assign accept = write && !fill_full;
  assign swap   = line_start && fill_full;

  always_comb begin
    fill_sel_next  = fill_sel ^ swap;
    valid_next     = valid | swap;
    fill_full_next = fill_full;
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    if (swap) begin
      fill_full_next = 1'b0;
    end else if (accept) begin
      if (wr_ptr == LAST) begin
        wr_ptr_next    = PTR_W'(PTR_RST);
        fill_full_next = 1'b1;
      end else begin
        wr_ptr_next = wr_ptr + 1'b1;
      end
    end
    // line_start takes priority over next, whether it swaps or replays
    if (line_start)
      rd_ptr_next = PTR_W'(PTR_RST);
    else if (next && valid && rd_ptr != LAST)
      rd_ptr_next = rd_ptr + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_sel  <= 1'b0;
      fill_full <= 1'b0;
      valid     <= 1'b0;
      wr_ptr    <= PTR_W'(PTR_RST);
      rd_ptr    <= PTR_W'(PTR_RST);
      underrun  <= 1'b0;
    end else begin
      fill_sel  <= fill_sel_next;
      fill_full <= fill_full_next;
      valid     <= valid_next;
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      underrun  <= line_start && !fill_full;
    end
  end

  // Both banks read at rd_ptr_next; the registered select picks the read bank.
  line_bank #(.WIDTH(WIDTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_bank0 (
    .clk   (clk),
    .we    (accept && !fill_sel),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr_next),
    .rdata (rdata0)
  );

  line_bank #(.WIDTH(WIDTH), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_bank1 (
    .clk   (clk),
    .we    (accept && fill_sel),
    .waddr (wr_ptr),
    .wdata (data_i),
    .raddr (rd_ptr_next),
    .rdata (rdata1)
  );

  assign pixel_o = valid ? (fill_sel ? rdata0 : rdata1) : DATA_W'(PIXEL_RST);

endmodule

// File: tb/tb_line_pingpong.sv
// Directed bench for line_pingpong: fill, swap, read-out, underrun/replay and reset corners.
module tb_line_pingpong;

  logic       clk = 1'b0;
  logic       reset;
  logic       write;
  logic [7:0] data_i;
  logic       ready;
  logic       line_start;
  logic       next;
  logic [7:0] pixel_o;
  logic       valid;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       ls;
    logic       nx;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_pix;
    logic       e_und;
  } vec_t;

  vec_t tbl [6];

  line_pingpong dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .data_i     (data_i),
    .ready      (ready),
    .line_start (line_start),
    .next       (next),
    .pixel_o    (pixel_o),
    .valid      (valid),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic ls, input logic nx);
    write = w; data_i = d; line_start = ls; next = nx;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // w, d, ls, nx | ready, valid, pixel, underrun  (applied right after a reset)
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};

    reset = 1'b1; write = 1'b0; data_i = 8'h00; line_start = 1'b0; next = 1'b0;
    #12;
    chk("rst_ready", int'(ready), 1);
    chk("rst_valid", int'(valid), 0);
    chk("rst_pixel", int'(pixel_o), 0);
    chk("rst_underrun", int'(underrun), 0);
    @(negedge clk) reset = 1'b0;

    // Fill bank 0 with index mod 256
    for (int i = 0; i < 320; i++) begin
      chk("fill_ready", int'(ready), 1);
      step(1'b1, 8'(i % 256), 1'b0, 1'b0);
    end
    chk("full_ready", int'(ready), 0);
    chk("full_valid", int'(valid), 0);

    // Write while full is ignored
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ignored_ready", int'(ready), 0);

    // Swap in line 0 and read it out, holding next past the end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("swap_valid", int'(valid), 1);
    chk("swap_ready", int'(ready), 1);
    chk("swap_pixel0", int'(pixel_o), 0);
    chk("swap_underrun", int'(underrun), 0);
    for (int k = 1; k <= 400; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("read_pixel", int'(pixel_o), (k <= 319 ? k : 319) % 256);
    end

    // Half fill bank 1, then line_start -> underrun and replay of bank 0
    for (int i = 0; i < 160; i++) step(1'b1, 8'((i + 100) % 256), 1'b0, 1'b0);
    chk("half_ready", int'(ready), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("half_underrun", int'(underrun), 1);
    chk("half_pixel", int'(pixel_o), 0);
    chk("half_valid", int'(valid), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("half_underrun_drop", int'(underrun), 0);
    chk("replay_pixel1", int'(pixel_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("replay_pixel2", int'(pixel_o), 2);

    // Finish the fill; final write coincides with line_start
    for (int i = 160; i < 319; i++) step(1'b1, 8'((i + 100) % 256), 1'b0, 1'b0);
    chk("pre_final_pixel", int'(pixel_o), 2);
    step(1'b1, 8'((319 + 100) % 256), 1'b1, 1'b0);
    chk("final_underrun", int'(underrun), 1);
    chk("final_ready", int'(ready), 0);
    chk("final_pixel", int'(pixel_o), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("late_swap_underrun", int'(underrun), 0);
    chk("late_swap_ready", int'(ready), 1);
    chk("late_swap_pixel", int'(pixel_o), 100);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("late_swap_pixel1", int'(pixel_o), 101);

    // Partially fill bank 0 while reading bank 1, then reset mid-line
    for (int i = 0; i < 100; i++) step(1'b1, 8'(i), 1'b0, i < 49);
    chk("pre_reset_pixel", int'(pixel_o), 150);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("async_rst_ready", int'(ready), 1);
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_pixel", int'(pixel_o), 0);
    @(negedge clk) reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      step(tbl[v].w, tbl[v].d, tbl[v].ls, tbl[v].nx);
      chk($sformatf("tbl%0d_ready", v), int'(ready), int'(tbl[v].e_ready));
      chk($sformatf("tbl%0d_valid", v), int'(valid), int'(tbl[v].e_valid));
      chk($sformatf("tbl%0d_pixel", v), int'(pixel_o), int'(tbl[v].e_pix));
      chk($sformatf("tbl%0d_underrun", v), int'(underrun), int'(tbl[v].e_und));
    end

    // Complete that line after the 0xAA entry and confirm it swaps in whole
    for (int i = 1; i < 320; i++) step(1'b1, 8'((i * 3) % 256), 1'b0, 1'b0);
    chk("post_rst_full", int'(ready), 0);
    chk("post_rst_pixel", int'(pixel_o), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_valid", int'(valid), 1);
    chk("post_rst_pix0", int'(pixel_o), 8'hAA);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_rst_pix1", int'(pixel_o), 3);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("ls_beats_next", int'(pixel_o), 8'hAA);
    chk("ls_beats_next_und", int'(underrun), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
